// File: rtl/mux_pkg.sv
// Shared constants and output-FSM encoding for the 4:1 round-robin merge.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Pointer value after reset; channel 0 is searched first.
  localparam logic [SEL_W-1:0] LAST_GNT_RST = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin arbiter: searches upward from last_gnt+1.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller gates the grant with its own load enable.
//
// Ports:
//   req      - per-channel request, bit i = channel i
//   last_gnt - index of the most recently served channel (lowest priority)
//   gnt      - one-hot grant, all zero when nothing is requesting
//   gnt_idx  - binary index of the granted channel (0 when gnt_any=0)
//   gnt_any  - at least one channel is requesting
module rr_arbiter_4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_gnt,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest candidate (last_gnt itself) down to the nearest
  // (last_gnt+1); the nearest requesting channel overwrites and wins.
  // The 2-bit add wraps 3->0 naturally.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = last_gnt + SEL_W'(k);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mux_4to1_rr.sv
// Merges four valid/ready channels into one registered stream tagged with source index.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: single output register; reloads on the consuming edge, so full rate with out_ready=1.
//
// Ports:
//   clk, rst_n        - rising-edge clock, async active-low reset
//   in_valid/in_ready - per-channel handshake, bit i = channel i
//   in_data           - channel i payload at [i*DATA_W +: DATA_W]
//   out_valid/out_ready, out_data, out_sel - registered output beat and its source index
module mux_4to1_rr
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  state_t            state;
  logic [SEL_W-1:0]  last_gnt;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              load_en;
  logic [DATA_W-1:0] gnt_data;

  rr_arbiter_4 u_arb (
    .req      (in_valid),
    .last_gnt (last_gnt),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  // The register can take a new beat when empty or when its beat leaves this edge.
  assign load_en  = (state == ST_EMPTY) || out_ready;

  // rst_n gates ready directly so no handshake is offered while reset is held,
  // even though load_en is already high in the reset state.
  assign in_ready = gnt & {NUM_CH{load_en & rst_n}};

  assign gnt_data  = in_data[gnt_idx*DATA_W +: DATA_W];
  assign out_valid = (state == ST_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      last_gnt <= LAST_GNT_RST;
    end else if (load_en) begin
      if (gnt_any) begin
        state    <= ST_FULL;
        out_data <= gnt_data;
        out_sel  <= gnt_idx;
        last_gnt <= gnt_idx;
      end else begin
        // Drain with nothing pending; the pointer keeps its value so idle
        // cycles never rotate priority.
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_mux_4to1_rr.sv
module tb_mux_4to1_rr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  mux_4to1_rr #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The model holds the beat it expects in the output register and the
  // channel it last served; the grant is the first requesting channel met
  // walking forward from the one after the last served.
  bit       m_valid;
  int       m_data;
  int       m_sel;
  int       m_last;

  function automatic int model_grant();
    if (m_valid && !out_ready) return -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_last + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    logic [3:0] r;
    g = model_grant();
    r = 4'b0000;
    if (rst_n && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0;
      m_data  = 0;
      m_sel   = 0;
      m_last  = 3;
    end else begin
      int g;
      g = model_grant();
      if (g >= 0) begin
        m_valid = 1;
        m_data  = int'(in_data[g*8 +: 8]);
        m_sel   = g;
        m_last  = g;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    chk("cmp_in_ready", 32'(in_ready), 32'(model_ready()));
    chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("cmp_out_data", 32'(out_data), 32'(m_data));
      chk("cmp_out_sel", 32'(out_sel), 32'(m_sel));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'hF;   // requests during reset must not be acknowledged
    in_data   = 32'h13_12_11_10;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // Full-rate rotation with every channel requesting.
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rot_ready_%0d", i), 32'(in_ready), 32'(1 << (i % 4)));
      chk($sformatf("rot_valid_%0d", i), 32'(out_valid), 32'(i > 0));
      if (i > 0) begin
        chk($sformatf("rot_sel_%0d", i), 32'(out_sel), 32'((i - 1) % 4));
        chk($sformatf("rot_data_%0d", i), 32'(out_data), 32'h10 + 32'((i - 1) % 4));
      end
      next_cycle();
    end
    in_valid = 4'b0000;
    repeat (2) next_cycle();

    // Pointer wrap: last served is 3, channels 0 and 3 request.
    in_valid = 4'b1001;
    @(negedge clk);
    chk("wrap_first", 32'(in_ready), 32'b0001);
    next_cycle();
    @(negedge clk);
    chk("wrap_second", 32'(in_ready), 32'b1000);
    chk("wrap_sel0", 32'(out_sel), 32'd0);
    next_cycle();
    in_valid = 4'b0000;
    repeat (2) next_cycle();

    // Idle cycles must not rotate priority.
    in_valid = 4'b0010;
    @(negedge clk);
    chk("idle_grant1", 32'(in_ready), 32'b0010);
    next_cycle();
    in_valid = 4'b0000;
    repeat (10) next_cycle();
    in_valid = 4'b0011;
    @(negedge clk);
    chk("idle_then_0", 32'(in_ready), 32'b0001);
    next_cycle();
    in_valid = 4'b0000;
    repeat (2) next_cycle();

    // Single requester on channel 2.
    in_data  = 32'h00_A5_00_00;
    in_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", 32'(in_ready), 32'b0100);
    next_cycle();
    in_valid = 4'b0000;
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_sel", 32'(out_sel), 32'd2);
    repeat (2) next_cycle();

    // Backpressure while holding 8'h3C from channel 0.
    in_data  = 32'h44_33_22_3C;
    in_valid = 4'b0001;
    next_cycle();
    out_ready = 1'b0;
    in_valid  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_data_%0d", i), 32'(out_data), 32'h3C);
      chk($sformatf("bp_sel_%0d", i), 32'(out_sel), 32'd0);
      chk($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd0);
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'b0010);
    next_cycle();
    @(negedge clk);
    chk("bp_reload_sel", 32'(out_sel), 32'd1);
    chk("bp_reload_data", 32'(out_data), 32'h22);
    chk("bp_reload_valid", 32'(out_valid), 32'd1);
    next_cycle();
    next_cycle();

    // Asynchronous reset mid-stream while FULL.
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_first_prio", 32'(in_ready), 32'b0001);
    next_cycle();

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      next_cycle();
    end
    rst_n = 1'b1;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
